// File: rtl/eth_mmio_pkg.sv
// eth_mmio_pkg
// Shared types for the ethernet MMIO arbiter slice.
//   - state_e        : arbiter sequencing states
//   - op_size_e      : MMIO access size encoding (1/2/4/8 bytes)
//   - eth_mmio_req_s : one latched request at the default widths
//   - onehot2        : turns a requester index into its 2-bit one-hot mask
package eth_mmio_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int TIMEOUT_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_4B = 2'd2,
        SIZE_8B = 2'd3
    } op_size_e;

    typedef struct packed {
        logic                      we;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        op_size_e                  size;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } eth_mmio_req_s;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/eth_mmio_rr_arb2.sv
// eth_mmio_rr_arb2
// Two-way round-robin arbiter. The requester named by the internal pointer
// wins when it is valid, otherwise the other one does. The pointer moves
// past the winner only when the winner is actually taken (yumi_i).
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i[1:0]         : request valids
//   yumi_i           : current grant has been consumed
//   grant_o          : index of the winning requester
//   grant_v_o        : some requester is valid (grant_o meaningful)
module eth_mmio_rr_arb2
    import eth_mmio_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [1:0] v_i,
    input  logic       yumi_i,
    output logic       grant_o,
    output logic       grant_v_o
);

    logic ptr;

    // The pointer holder has priority; fall back to the other requester.
    always_comb begin
        grant_o   = v_i[ptr] ? ptr : ~ptr;
        grant_v_o = |v_i;
    end

    // After a grant is used, the loser of that round gets priority next.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr <= 1'b0;
        end else if (yumi_i) begin
            ptr <= ~grant_o;
        end
    end

endmodule

// File: rtl/eth_mmio_arbiter.sv
// eth_mmio_arbiter
// Shares the ethernet controller's single MMIO port between the host CPU
// bridge (requester 0) and the descriptor/DMA engine (requester 1). One
// operation is in flight at a time; the downstream command is registered
// and the response is held per requester until it is consumed.
// Optional feature macro: ETH_MMIO_TIMEOUT_EN (read timeout abort).
// Ports:
//   clk_i, reset_n_i                  : clock, asynchronous active-low reset
//   req_v_i/req_ready_o               : per-requester request handshake
//   req_we_i/req_addr_i/req_size_i/req_wdata_i : packed per-requester command
//   resp_v_o/resp_ready_i             : per-requester response handshake
//   resp_data_o/resp_err_o            : shared response payload
//   addr_o/op_size_o/write_data_o     : command buses to the controller
//   write_en_o/read_en_o              : one-cycle command strobes
//   read_data_i/read_data_v_i         : controller read return
module eth_mmio_arbiter
    import eth_mmio_pkg::*;
#(
    parameter int addr_width_p = ADDR_WIDTH_DEF,
    parameter int data_width_p = DATA_WIDTH_DEF,
    parameter int timeout_p    = TIMEOUT_DEF
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [1:0]                req_v_i,
    output logic [1:0]                req_ready_o,
    input  logic [1:0]                req_we_i,
    input  logic [2*addr_width_p-1:0] req_addr_i,
    input  logic [3:0]                req_size_i,
    input  logic [2*data_width_p-1:0] req_wdata_i,
    output logic [1:0]                resp_v_o,
    input  logic [1:0]                resp_ready_i,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic                      resp_err_o,
    output logic [addr_width_p-1:0]   addr_o,
    output logic [1:0]                op_size_o,
    output logic [data_width_p-1:0]   write_data_o,
    output logic                      write_en_o,
    output logic                      read_en_o,
    input  logic [data_width_p-1:0]   read_data_i,
    input  logic                      read_data_v_i
);

    if (timeout_p < 2) begin : g_bad_timeout
        $error("eth_mmio_arbiter: timeout_p must be at least 2");
    end

    state_e state;
    logic   grant_q;
    logic   we_q;
    logic   grant;
    logic   grant_v;
    logic   yumi;

`ifdef ETH_MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_p);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // A grant is only taken while idle, so the round-robin pointer moves
    // exactly once per accepted request.
    assign yumi = (state == IDLE) && grant_v;

    eth_mmio_rr_arb2 u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (req_v_i),
        .yumi_i    (yumi),
        .grant_o   (grant),
        .grant_v_o (grant_v)
    );

    // Ready is combinational but gated by reset so that a requester never
    // sees an accept while the block is held in reset.
    assign req_ready_o = (yumi && reset_n_i) ? onehot2(grant) : 2'b00;

`ifndef ETH_MMIO_TIMEOUT_EN
    assign resp_err_o = 1'b0;
`endif

    // Sequencer: IDLE accepts and registers the command straight onto the
    // controller buses (they double as the request latch and hold their
    // value afterwards), ISSUE is the single strobe cycle, WAIT collects
    // the read return and RESP holds the answer until it is consumed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_o       <= '0;
            op_size_o    <= '0;
            write_data_o <= '0;
            write_en_o   <= 1'b0;
            read_en_o    <= 1'b0;
            resp_v_o     <= 2'b00;
            resp_data_o  <= '0;
`ifdef ETH_MMIO_TIMEOUT_EN
            resp_err_o   <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            write_en_o <= 1'b0;
            read_en_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_v) begin
                        grant_q      <= grant;
                        we_q         <= req_we_i[grant];
                        addr_o       <= grant ? req_addr_i[addr_width_p +: addr_width_p]
                                              : req_addr_i[0 +: addr_width_p];
                        op_size_o    <= grant ? req_size_i[3:2] : req_size_i[1:0];
                        write_data_o <= grant ? req_wdata_i[data_width_p +: data_width_p]
                                              : req_wdata_i[0 +: data_width_p];
                        write_en_o   <= req_we_i[grant];
                        read_en_o    <= ~req_we_i[grant];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef ETH_MMIO_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (we_q) begin
                        resp_data_o <= '0;
                        resp_v_o    <= onehot2(grant_q);
`ifdef ETH_MMIO_TIMEOUT_EN
                        resp_err_o  <= 1'b0;
`endif
                        state       <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (read_data_v_i) begin
                        resp_data_o <= read_data_i;
                        resp_v_o    <= onehot2(grant_q);
`ifdef ETH_MMIO_TIMEOUT_EN
                        resp_err_o  <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef ETH_MMIO_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(timeout_p - 1)) begin
                        resp_data_o <= '1;
                        resp_v_o    <= onehot2(grant_q);
                        resp_err_o  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready_i[grant_q]) begin
                        resp_v_o <= 2'b00;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
